timp_setter: RTL and testbench

- User-facing time-entry controller; drives the load side of counter_timp.
- Takes debounced push-button inputs and lets the operator edit an hours/minutes value for one of two time slots.
- On commit, presents the value on timp_ore1/timp_minute1 or timp_ore2/timp_minute2 and pulses load_1 or load_2 for exactly one clock.
- Also exports the in-progress edit value and current field for the display path.

---
 rtl/timp_setter.sv | 199 +++++++++++++++++++
 tb/tb_timp_setter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timp_setter.sv
// Time-entry controller: edits hours/minutes for one of two slots from push buttons and
// commits the result with a one-cycle load strobe. Define TIMP_SETTER_AUTO_REPEAT_EN for held-button auto-repeat.
module timp_setter #(
    parameter int ORE_MAX        = 23,
    parameter int MIN_MAX        = 59,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_PERIOD  = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       btn_ok,
    input  logic       slot_sel,
    output logic [4:0] timp_ore1,
    output logic [5:0] timp_minute1,
    output logic [4:0] timp_ore2,
    output logic [5:0] timp_minute2,
    output logic       load_1,
    output logic       load_2,
    output logic [4:0] edit_ore,
    output logic [5:0] edit_minute,
    output logic [1:0] edit_field,
    output logic       busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_EDIT_ORE = 2'd1;
    localparam logic [1:0] S_EDIT_MIN = 2'd2;
    localparam logic [1:0] S_LOAD     = 2'd3;

    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]    ORE_TOP = 5'(ORE_MAX);
    localparam logic [5:0]    MIN_TOP = 6'(MIN_MAX);

    if (TIMEOUT_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("timp_setter: TIMEOUT_CYCLES must be >= 2, REPEAT_DELAY/REPEAT_PERIOD >= 1");
    end

    // Button vectors are ordered {ok, inc, set}.
    logic [2:0]    btn_s_q, btn_s_d, btn_p_q, btn_p_d, ev;
    logic [1:0]    state_q, state_d;
    logic          target_q, target_d;
    logic [4:0]    edit_ore_q, edit_ore_d, ore1_q, ore1_d, ore2_q, ore2_d;
    logic [5:0]    edit_min_q, edit_min_d, min1_q, min1_d, min2_q, min2_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          rep_fire, inc_pulse;

    always_comb begin
        btn_s_d    = {btn_ok, btn_inc, btn_set};
        btn_p_d    = btn_s_q;
        ev         = btn_s_q & ~btn_p_q;
        inc_pulse  = ev[1] | rep_fire;
        state_d    = state_q;
        target_d   = target_q;
        edit_ore_d = edit_ore_q;
        edit_min_d = edit_min_q;
        ore1_d     = ore1_q;
        min1_d     = min1_q;
        ore2_d     = ore2_q;
        min2_d     = min2_q;
        to_cnt_d   = to_cnt_q;

        case (state_q)
            S_IDLE: begin
                to_cnt_d = '0;
                if (ev[0]) begin
                    target_d   = slot_sel;
                    edit_ore_d = slot_sel ? ore2_q : ore1_q;
                    edit_min_d = slot_sel ? min2_q : min1_q;
                    state_d    = S_EDIT_ORE;
                end
            end
            S_EDIT_ORE, S_EDIT_MIN: begin
                // ok takes priority over any increment arriving in the same cycle.
                if (ev[2]) begin
                    to_cnt_d = '0;
                    if (state_q == S_EDIT_ORE) begin
                        state_d = S_EDIT_MIN;
                    end else begin
                        state_d = S_LOAD;
                        if (target_q) begin
                            ore2_d = edit_ore_q;
                            min2_d = edit_min_q;
                        end else begin
                            ore1_d = edit_ore_q;
                            min1_d = edit_min_q;
                        end
                    end
                end else if (inc_pulse) begin
                    to_cnt_d = '0;
                    if (state_q == S_EDIT_ORE) begin
                        edit_ore_d = (edit_ore_q == ORE_TOP) ? 5'd0 : edit_ore_q + 5'd1;
                    end else begin
                        edit_min_d = (edit_min_q == MIN_TOP) ? 6'd0 : edit_min_q + 6'd1;
                    end
                end else if (ev[0]) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d  = S_IDLE;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                to_cnt_d = '0;
            end
        endcase
    end

`ifdef TIMP_SETTER_AUTO_REPEAT_EN
    localparam int            HW       = $clog2(REPEAT_DELAY + 1);
    localparam int            RW       = $clog2(REPEAT_PERIOD + 1);
    localparam logic [HW-1:0] HOLD_TOP = HW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_PERIOD - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          editing;

    // hold_q saturates at the delay; rep_q then paces the repeats, firing on each wrap to 0.
    always_comb begin
        editing  = (state_q == S_EDIT_ORE) || (state_q == S_EDIT_MIN);
        rep_fire = editing && btn_s_q[1] && (hold_q == HOLD_TOP) && (rep_q == '0);
        hold_d   = hold_q;
        rep_d    = rep_q;
        if (!btn_s_q[1] || !editing || (state_d != state_q)) begin
            hold_d = '0;
            rep_d  = '0;
        end else if (hold_q != HOLD_TOP) begin
            hold_d = hold_q + HW'(1);
        end else begin
            rep_d = (rep_q == REP_LAST) ? '0 : rep_q + RW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q <= '0;
            rep_q  <= '0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
`else
    always_comb rep_fire = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_s_q    <= '0;
            btn_p_q    <= '0;
            state_q    <= S_IDLE;
            target_q   <= 1'b0;
            edit_ore_q <= '0;
            edit_min_q <= '0;
            ore1_q     <= '0;
            min1_q     <= '0;
            ore2_q     <= '0;
            min2_q     <= '0;
            to_cnt_q   <= '0;
        end else begin
            btn_s_q    <= btn_s_d;
            btn_p_q    <= btn_p_d;
            state_q    <= state_d;
            target_q   <= target_d;
            edit_ore_q <= edit_ore_d;
            edit_min_q <= edit_min_d;
            ore1_q     <= ore1_d;
            min1_q     <= min1_d;
            ore2_q     <= ore2_d;
            min2_q     <= min2_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    always_comb begin
        timp_ore1    = ore1_q;
        timp_minute1 = min1_q;
        timp_ore2    = ore2_q;
        timp_minute2 = min2_q;
        edit_ore     = edit_ore_q;
        edit_minute  = edit_min_q;
        load_1       = (state_q == S_LOAD) && !target_q;
        load_2       = (state_q == S_LOAD) && target_q;
        busy         = (state_q != S_IDLE);
        case (state_q)
            S_EDIT_ORE: edit_field = 2'b01;
            S_EDIT_MIN: edit_field = 2'b10;
            default:    edit_field = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_timp_setter.sv
// Directed bench for timp_setter: table of full edit/commit sequences plus hand-written
// latency, wrap, simultaneous-button, timeout, reset and auto-repeat sequences.
module tb_timp_setter;

    localparam logic [2:0] B_SET = 3'b001;
    localparam logic [2:0] B_INC = 3'b010;
    localparam logic [2:0] B_OK  = 3'b100;
`ifdef TIMP_SETTER_AUTO_REPEAT_EN
    localparam int EXP_REP = 6;
`else
    localparam int EXP_REP = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_set = 1'b0, btn_inc = 1'b0, btn_ok = 1'b0, slot_sel = 1'b0;
    logic [4:0] timp_ore1, timp_ore2, edit_ore;
    logic [5:0] timp_minute1, timp_minute2, edit_minute;
    logic       load_1, load_2, busy;
    logic [1:0] edit_field;

    int n_checks = 0;
    int n_fail   = 0;
    int l1_cnt   = 0;
    int l2_cnt   = 0;
    int cap_ore1 = 0, cap_min1 = 0, cap_ore2 = 0, cap_min2 = 0;
    int b1, b2;

    timp_setter #(
        .ORE_MAX(23), .MIN_MAX(59), .TIMEOUT_CYCLES(20), .REPEAT_DELAY(5), .REPEAT_PERIOD(2)
    ) dut (
        .clock(clock), .reset(reset), .btn_set(btn_set), .btn_inc(btn_inc), .btn_ok(btn_ok),
        .slot_sel(slot_sel), .timp_ore1(timp_ore1), .timp_minute1(timp_minute1),
        .timp_ore2(timp_ore2), .timp_minute2(timp_minute2), .load_1(load_1), .load_2(load_2),
        .edit_ore(edit_ore), .edit_minute(edit_minute), .edit_field(edit_field), .busy(busy)
    );

    always #5 clock = ~clock;

    // Load strobes counted and data captured on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (load_1) begin
            l1_cnt   <= l1_cnt + 1;
            cap_ore1 <= int'(timp_ore1);
            cap_min1 <= int'(timp_minute1);
        end
        if (load_2) begin
            l2_cnt   <= l2_cnt + 1;
            cap_ore2 <= int'(timp_ore2);
            cap_min2 <= int'(timp_minute2);
        end
    end

    typedef struct {
        logic       slot;
        int         n_ore;
        int         n_min;
        logic [4:0] o1;
        logic [5:0] m1;
        logic [4:0] o2;
        logic [5:0] m2;
        int         l1;
        int         l2;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic press(input logic [2:0] m);
        {btn_ok, btn_inc, btn_set} = m;
        tick();
        {btn_ok, btn_inc, btn_set} = 3'b000;
        tick();
    endtask

    task automatic run_edit(input logic slot, input int n_ore, input int n_min);
        slot_sel = slot;
        press(B_SET);
        repeat (n_ore) press(B_INC);
        press(B_OK);
        repeat (n_min) press(B_INC);
        press(B_OK);
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".timp_ore1"}, int'(timp_ore1), 0);
        check({tag, ".timp_minute1"}, int'(timp_minute1), 0);
        check({tag, ".timp_ore2"}, int'(timp_ore2), 0);
        check({tag, ".timp_minute2"}, int'(timp_minute2), 0);
        check({tag, ".edit_ore"}, int'(edit_ore), 0);
        check({tag, ".edit_minute"}, int'(edit_minute), 0);
        check({tag, ".load_1"}, int'(load_1), 0);
        check({tag, ".load_2"}, int'(load_2), 0);
        check({tag, ".edit_field"}, int'(edit_field), 0);
        check({tag, ".busy"}, int'(busy), 0);
    endtask

    initial begin
        //        slot n_ore n_min  o1  m1  o2  m2 l1 l2
        vecs[0] = '{1'b0, 12, 35, 5'd12, 6'd35, 5'd0,  6'd0,  1, 0};
        vecs[1] = '{1'b1, 23, 59, 5'd12, 6'd35, 5'd23, 6'd59, 0, 1};
        vecs[2] = '{1'b1,  1,  1, 5'd12, 6'd35, 5'd0,  6'd0,  0, 1};
        vecs[3] = '{1'b0,  5, 30, 5'd17, 6'd5,  5'd0,  6'd0,  1, 0};
        vecs[4] = '{1'b1,  3,  0, 5'd17, 6'd5,  5'd3,  6'd0,  0, 1};

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check_zero("reset");

        // btn_set latency and hour/minute wrap on slot 2
        b1 = l1_cnt;
        b2 = l2_cnt;
        slot_sel = 1'b1;
        btn_set  = 1'b1;
        tick();
        check("set_lat1.edit_field", int'(edit_field), 0);
        tick();
        check("set_lat2.edit_field", int'(edit_field), 1);
        check("set_lat2.busy", int'(busy), 1);
        btn_set = 1'b0;
        tick();
        repeat (23) press(B_INC);
        check("ore_top", int'(edit_ore), 23);
        press(B_INC);
        check("ore_wrap", int'(edit_ore), 0);
        press(B_OK);
        check("field_min", int'(edit_field), 2);
        repeat (59) press(B_INC);
        check("min_top", int'(edit_minute), 59);
        press(B_INC);
        check("min_wrap", int'(edit_minute), 0);
        btn_ok = 1'b1;
        tick();
        check("ok_lat1.load_2", int'(load_2), 0);
        tick();
        check("ok_lat2.load_2", int'(load_2), 1);
        check("ok_lat2.timp_ore2", int'(timp_ore2), 0);
        check("ok_lat2.timp_minute2", int'(timp_minute2), 0);
        btn_ok = 1'b0;
        tick();
        check("ok_lat3.load_2", int'(load_2), 0);
        check("ok_lat3.busy", int'(busy), 0);
        check("wrap.load2_pulses", l2_cnt - b2, 1);
        check("wrap.load1_pulses", l1_cnt - b1, 0);

        // Table of full edit/commit sequences
        for (int i = 0; i < 5; i++) begin
            b1 = l1_cnt;
            b2 = l2_cnt;
            run_edit(vecs[i].slot, vecs[i].n_ore, vecs[i].n_min);
            tick();
            check($sformatf("vec%0d.timp_ore1", i), int'(timp_ore1), int'(vecs[i].o1));
            check($sformatf("vec%0d.timp_minute1", i), int'(timp_minute1), int'(vecs[i].m1));
            check($sformatf("vec%0d.timp_ore2", i), int'(timp_ore2), int'(vecs[i].o2));
            check($sformatf("vec%0d.timp_minute2", i), int'(timp_minute2), int'(vecs[i].m2));
            check($sformatf("vec%0d.load1_pulses", i), l1_cnt - b1, vecs[i].l1);
            check($sformatf("vec%0d.load2_pulses", i), l2_cnt - b2, vecs[i].l2);
            if (vecs[i].l1 != 0) begin
                check($sformatf("vec%0d.cap_ore1", i), cap_ore1, int'(vecs[i].o1));
                check($sformatf("vec%0d.cap_min1", i), cap_min1, int'(vecs[i].m1));
            end else begin
                check($sformatf("vec%0d.cap_ore2", i), cap_ore2, int'(vecs[i].o2));
                check($sformatf("vec%0d.cap_min2", i), cap_min2, int'(vecs[i].m2));
            end
        end

        // inc and ok together in EDIT_MIN: ok wins, increment discarded (slot 1 at 17:05)
        b1 = l1_cnt;
        slot_sel = 1'b0;
        press(B_SET);
        press(B_OK);
        press(B_INC);
        press(B_INC);
        check("simul.pre_minute", int'(edit_minute), 7);
        btn_inc = 1'b1;
        btn_ok  = 1'b1;
        tick();
        tick();
        check("simul.load_1", int'(load_1), 1);
        check("simul.timp_ore1", int'(timp_ore1), 17);
        check("simul.timp_minute1", int'(timp_minute1), 7);
        btn_inc = 1'b0;
        btn_ok  = 1'b0;
        tick();
        check("simul.load1_pulses", l1_cnt - b1, 1);

        // Idle timeout: back to IDLE 20 cycles after entering EDIT_ORE, no load
        b1 = l1_cnt;
        b2 = l2_cnt;
        press(B_SET);
        repeat (19) tick();
        check("timeout19.busy", int'(busy), 1);
        tick();
        check("timeout20.busy", int'(busy), 0);
        check("timeout20.edit_field", int'(edit_field), 0);
        check("timeout.edit_ore_kept", int'(edit_ore), 17);
        check("timeout.timp_ore1", int'(timp_ore1), 17);
        check("timeout.timp_minute1", int'(timp_minute1), 7);
        check("timeout.load_pulses", (l1_cnt - b1) + (l2_cnt - b2), 0);

        // Reset in EDIT_MIN clears everything, no load
        b1 = l1_cnt;
        press(B_SET);
        press(B_OK);
        press(B_INC);
        check("pre_reset.edit_field", int'(edit_field), 2);
        reset = 1'b1;
        tick();
        check_zero("mid_reset");
        reset = 1'b0;
        tick();
        tick();
        check("mid_reset.load1_pulses", l1_cnt - b1, 0);

        // Held btn_inc for 15 cycles in EDIT_ORE from 0
        slot_sel = 1'b0;
        press(B_SET);
        btn_inc = 1'b1;
        repeat (15) tick();
        btn_inc = 1'b0;
        repeat (3) tick();
        check("hold.edit_ore", int'(edit_ore), EXP_REP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
